// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with a shift counter.
//   Operations: hold, shift left/right, rotate left/right, parallel load, sync clear.
//   Optional feature macro: UNIV_SHIFT_REG_PARITY_EN (adds the 'parity' output).
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   en         operation enable; low holds all state
//   mode[2:0]  operation select
//   sin_lsb    serial input into bit 0 on shift left
//   sin_msb    serial input into bit WIDTH-1 on shift right
//   pdin       parallel load data
//   q          register contents
//   so_msb     tap of q[WIDTH-1]
//   so_lsb     tap of q[0]
//   shift_cnt  shift/rotate count since last load/clear, modulo WIDTH
//   word_done  one-cycle pulse after a full word has been shifted
//   parity     (macro only) XOR reduction of q
module univ_shift_reg #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_word_done_nxt;
  logic             w_is_shift;
  logic             w_is_reload;

  // Next-state data path and counter
  always_comb begin
    w_q_nxt         = r_q;
    w_cnt_nxt       = r_cnt;
    w_word_done_nxt = 1'b0;
    w_is_shift      = 1'b0;
    w_is_reload     = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin_lsb};
          w_is_shift = 1'b1;
        end
        MODE_SHR: begin
          w_q_nxt    = {sin_msb, r_q[WIDTH-1:1]};
          w_is_shift = 1'b1;
        end
        MODE_ROL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_is_shift = 1'b1;
        end
        MODE_ROR: begin
          w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
          w_is_shift = 1'b1;
        end
        MODE_LOAD: begin
          w_q_nxt     = pdin;
          w_is_reload = 1'b1;
        end
        MODE_CLEAR: begin
          w_q_nxt     = '0;
          w_is_reload = 1'b1;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end

    // Wrap explicitly at WIDTH so non-power-of-two widths count correctly
    if (w_is_shift) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt       = '0;
        w_word_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (w_is_reload) begin
      w_cnt_nxt = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q         <= '0;
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_q         <= w_q_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word_done <= w_word_done_nxt;
    end
  end

  assign q         = r_q;
  assign so_msb    = r_q[WIDTH-1];
  assign so_lsb    = r_q[0];
  assign shift_cnt = r_cnt;
  assign word_done = r_word_done;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  assign parity = ^r_q;
`endif

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, successor to the fixed 4-bit serial-in/serial-out shifter.
- Supports hold, left/right shift, left/right rotate, parallel load and synchronous clear.
- Has independent serial inputs at each end, parallel output, and a shift counter that flags each completed word.
- Used as a serializer/deserializer front end and as a general data-path delay/alignment element.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the shift counter. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when low, all state holds regardless of mode.
- mode  input  3  operation select (see Behaviour).
- sin_lsb  input  1  serial input entering bit 0 on shift-left.
- sin_msb  input  1  serial input entering bit WIDTH-1 on shift-right.
- pdin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- so_msb  output  1  equals q[WIDTH-1].
- so_lsb  output  1  equals q[0].
- shift_cnt  output  CNT_W  number of shift/rotate operations since the last load/clear, modulo WIDTH.
- word_done  output  1  one-cycle pulse when a full word has been shifted.

Behaviour:
- Reset: clr high clears q, shift_cnt and word_done to 0 immediately, independent of clk. Deassertion takes effect at the next rising edge. Reset mid-operation discards any partial word; no word_done is produced for it.
- All state updates on the rising edge of clk, only when en=1 and clr=0. One-cycle latency: q reflects the operation at the edge after it is presented.
- mode encoding (applied when en=1):
  - 000 hold.
  - 001 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
  - 010 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
  - 011 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 parallel load: q <= pdin.
  - 110 synchronous clear: q <= 0.
  - 111 reserved; behaves as hold.
- so_msb and so_lsb are continuous taps of the register. They carry no extra delay and are not glitch-filtered.
- Counter:
  - Modes 001–100 increment shift_cnt.
  - On the shift that moves shift_cnt from WIDTH-1, shift_cnt wraps to 0 and word_done is high for the following cycle.
  - Modes 101 and 110 force shift_cnt to 0 and word_done to 0.
  - Hold, reserved mode and en=0 leave shift_cnt unchanged and drive word_done to 0.
- word_done is a registered pulse, never high for two consecutive cycles unless WIDTH shifts complete back-to-back (only possible when WIDTH=1, which is illegal).
- When WIDTH is not a power of two, shift_cnt wraps at WIDTH, not at 2^CNT_W.
- Unknown/X on mode while en=1 is a protocol violation; no behaviour is guaranteed.

Optional Feature:
- Macro: UNIV_SHIFT_REG_PARITY_EN.
- Defined: adds output port parity (1 bit) = XOR of all bits of q, combinational from the register. It is 0 after reset.
- Undefined: the parity port does not exist; the remaining behaviour is identical.

Test Plan:
- Reset: drive clr=1 mid-stream with q=8'hA5 and shift_cnt=3 -> q=0, shift_cnt=0, word_done=0 without waiting for a clk edge. After clr=0, the first shift starts the count at 1.
- Serial-in left: from reset, mode=001, en=1, shift in sin_lsb sequence 1,0,1,1,0,0,1,0 (MSB first) -> q=8'hB2 after 8 edges. shift_cnt returns to 0 and word_done is high exactly one cycle after the 8th edge.
- Load then rotate: load pdin=8'h81 (mode=101), then 3× rotate right -> q=8'h30 with so_lsb=0. Then 3× rotate left -> q=8'h81. shift_cnt=6 and no word_done.
- Shift right with serial fill: q=8'hF0, mode=010, sin_msb=0 for 4 edges -> q=8'h0F, so_lsb=1.
- Enable/hold: q=8'h3C, mode=001, en=0 for 5 cycles -> q, shift_cnt and word_done unchanged. Repeat with mode=000 and mode=111 and en=1 -> unchanged.
- Load/clear interrupting count: 5 shifts, then mode=110 -> q=0, shift_cnt=0. Then 8 shifts -> single word_done pulse. With UNIV_SHIFT_REG_PARITY_EN, loading 8'h07 -> parity=1 and loading 8'h03 -> parity=0.
